// File: rtl/bram_port_arb_pkg.sv
// Shared types and constants for the two-requester block RAM port arbiter.
// Holds the FSM state encoding, the RAM data width and the request bundle.
package bram_arb_pkg;

    localparam int DW     = 9;
    localparam int AW_MAX = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    // Requester command; addr is zero-extended to the widest supported port.
    typedef struct packed {
        logic              we;
        logic [AW_MAX-1:0] addr;
        logic [DW-1:0]     wdata;
    } req_t;

endpackage

// File: rtl/bram_port_arb_if.sv
// Bundle of requester handshakes and RAM port signals around bram_port_arb.
// The arbiter uses the slave modport; requesters and the RAM sit on master.
interface bram_port_arb_if #(
    parameter int ADDR_W = 9
);
    import bram_arb_pkg::*;

    logic              r0_valid;
    logic              r0_ready;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DW-1:0]     r0_wdata;
    logic              r0_rvalid;
    logic [DW-1:0]     r0_rdata;

    logic              r1_valid;
    logic              r1_ready;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DW-1:0]     r1_wdata;
    logic              r1_rvalid;
    logic [DW-1:0]     r1_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DW-1:0]     ram_din;
    logic              ram_ssr;
    logic [DW-1:0]     ram_dout;
    logic              init_done;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        input  ram_dout,
        output r0_ready, r0_rvalid, r0_rdata,
        output r1_ready, r1_rvalid, r1_rdata,
        output ram_en, ram_we, ram_addr, ram_din, ram_ssr, init_done
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        output ram_dout,
        input  r0_ready, r0_rvalid, r0_rdata,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  ram_en, ram_we, ram_addr, ram_din, ram_ssr, init_done
    );

endinterface

// File: rtl/bram_rr_arb2.sv
// Two-way round-robin arbiter: same-cycle grant, pointer moves to the
// loser after every granted transfer so contention alternates.
module bram_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);

    logic       r_ptr;
    logic [1:0] w_gnt;
    logic       w_idx;

    // Grant decode: a lone requester wins, on contention the pointer decides.
    always_comb begin
        w_gnt = 2'b00;
        w_idx = 1'b0;
        if (i_en) begin
            case (i_req)
                2'b01: begin
                    w_gnt = 2'b01;
                    w_idx = 1'b0;
                end
                2'b10: begin
                    w_gnt = 2'b10;
                    w_idx = 1'b1;
                end
                2'b11: begin
                    w_idx = r_ptr;
                    w_gnt = r_ptr ? 2'b10 : 2'b01;
                end
                default: begin
                    w_gnt = 2'b00;
                    w_idx = 1'b0;
                end
            endcase
        end else begin
            w_gnt = 2'b00;
            w_idx = 1'b0;
        end
    end

    // Pointer register: favour the other requester after any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (|w_gnt) begin
            r_ptr <= ~w_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_idx = w_idx;

endmodule

// File: rtl/bram_port_arb.sv
// Shares one RAMB16_S9_S9 port between two requesters, routes read data
// back to the issuer, and optionally zero-fills the RAM after reset.
module bram_port_arb
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter bit INIT_CLEAR = 1'b1,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    bram_port_arb_if.slave bus
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              r_init_done;
    logic              r_tag_vld;
    logic              r_tag_id;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DW-1:0]     r_rdata0;
    logic [DW-1:0]     r_rdata1;

    logic              w_arb_en;
    logic [1:0]        w_gnt;
    logic              w_gnt_idx;
    req_t              w_req0;
    req_t              w_req1;
    req_t              w_win;
    logic              w_rd_acc;
    logic              w_rsp0;
    logic              w_rsp1;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DW-1:0]     w_ram_din;

    assign w_arb_en = rst_n & (r_state == RUN);

    bram_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_arb_en),
        .i_req     ({bus.r1_valid, bus.r0_valid}),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // Pack both commands and select the winner's.
    always_comb begin
        w_req0.we    = bus.r0_we;
        w_req0.addr  = AW_MAX'(bus.r0_addr);
        w_req0.wdata = bus.r0_wdata;
        w_req1.we    = bus.r1_we;
        w_req1.addr  = AW_MAX'(bus.r1_addr);
        w_req1.wdata = bus.r1_wdata;
        w_win        = w_gnt_idx ? w_req1 : w_req0;
    end

    // Next state and RAM port drive: zero-fill sweep, then arbitrated access.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_din   = '0;
        case (r_state)
            INIT: begin
                w_ram_en   = 1'b1;
                w_ram_we   = 1'b1;
                w_ram_addr = r_cnt[ADDR_W-1:0];
                w_cnt_nxt  = r_cnt + CNT_ONE;
                if (w_cnt_nxt[ADDR_W]) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = INIT;
                end
            end
            RUN: begin
                if (|w_gnt) begin
                    w_ram_en   = 1'b1;
                    w_ram_we   = w_win.we;
                    w_ram_addr = w_win.addr[ADDR_W-1:0];
                    w_ram_din  = w_win.wdata;
                end else begin
                    w_ram_en   = 1'b0;
                    w_ram_we   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = INIT_CLEAR ? INIT : RUN;
            end
        endcase
    end

    // State, sweep counter and init_done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT_CLEAR ? INIT : RUN;
            r_cnt       <= '0;
            r_init_done <= !INIT_CLEAR;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == INIT) && (w_state_nxt == RUN)) begin
                r_init_done <= 1'b1;
            end else begin
                r_init_done <= r_init_done;
            end
        end
    end

    assign w_rd_acc = (|w_gnt) & ~w_win.we;
    assign w_rsp0   = r_tag_vld & ~r_tag_id;
    assign w_rsp1   = r_tag_vld &  r_tag_id;

    // Read tag pipeline and per-requester data hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= 1'b0;
            r_tag_id  <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_tag_vld <= w_rd_acc;
            r_tag_id  <= w_gnt_idx;
            r_rvalid0 <= w_rsp0;
            r_rvalid1 <= w_rsp1;
            if (w_rsp0) begin
                r_rdata0 <= bus.ram_dout;
            end else begin
                r_rdata0 <= r_rdata0;
            end
            if (w_rsp1) begin
                r_rdata1 <= bus.ram_dout;
            end else begin
                r_rdata1 <= r_rdata1;
            end
        end
    end

    assign bus.r0_ready  = w_gnt[0];
    assign bus.r1_ready  = w_gnt[1];
    assign bus.r0_rvalid = OUT_REG ? r_rvalid0 : w_rsp0;
    assign bus.r1_rvalid = OUT_REG ? r_rvalid1 : w_rsp1;
    assign bus.r0_rdata  = OUT_REG ? r_rdata0 : (w_rsp0 ? bus.ram_dout : r_rdata0);
    assign bus.r1_rdata  = OUT_REG ? r_rdata1 : (w_rsp1 ? bus.ram_dout : r_rdata1);

    // The RAM port stays quiet while reset is held.
    assign bus.ram_en    = rst_n & w_ram_en;
    assign bus.ram_we    = rst_n & w_ram_we;
    assign bus.ram_addr  = rst_n ? w_ram_addr : '0;
    assign bus.ram_din   = rst_n ? w_ram_din : '0;
    assign bus.ram_ssr   = 1'b0;
    assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_bram_port_arb.sv
// Random and directed stimulus for bram_port_arb (OUT_REG 0 and 1 side by side)
// checked against a transaction-level model of memory, fairness and responses.
module tb_bram_port_arb;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        int         cyc;
        int         id;
        logic [8:0] d;
    } rsp_t;

    logic clk;
    logic rst_n;
    logic scramble;
    logic v0, we0, v1, we1;
    logic [AW-1:0] a0, a1;
    logic [8:0] d0, d1;

    bram_port_arb_if #(.ADDR_W(AW)) ifc0 ();
    bram_port_arb_if #(.ADDR_W(AW)) ifc1 ();

    bram_port_arb #(.ADDR_W(AW), .INIT_CLEAR(1'b1), .OUT_REG(1'b0)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (ifc0.slave)
    );
    bram_port_arb #(.ADDR_W(AW), .INIT_CLEAR(1'b1), .OUT_REG(1'b1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (ifc1.slave)
    );

    assign ifc0.r0_valid = v0;  assign ifc1.r0_valid = v0;
    assign ifc0.r0_we    = we0; assign ifc1.r0_we    = we0;
    assign ifc0.r0_addr  = a0;  assign ifc1.r0_addr  = a0;
    assign ifc0.r0_wdata = d0;  assign ifc1.r0_wdata = d0;
    assign ifc0.r1_valid = v1;  assign ifc1.r1_valid = v1;
    assign ifc0.r1_we    = we1; assign ifc1.r1_we    = we1;
    assign ifc0.r1_addr  = a1;  assign ifc1.r1_addr  = a1;
    assign ifc0.r1_wdata = d1;  assign ifc1.r1_wdata = d1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural block RAMs (read-first, one-cycle read) behind each DUT.
    logic [8:0] mem0 [DEPTH];
    logic [8:0] mem1 [DEPTH];
    logic [8:0] dout0, dout1;
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem0[i] <= 9'($urandom);
                mem1[i] <= 9'($urandom);
            end
        end else begin
            if (ifc0.ram_en) begin
                if (ifc0.ram_we) mem0[ifc0.ram_addr] <= ifc0.ram_din;
                dout0 <= mem0[ifc0.ram_addr];
            end
            if (ifc1.ram_en) begin
                if (ifc1.ram_we) mem1[ifc1.ram_addr] <= ifc1.ram_din;
                dout1 <= mem1[ifc1.ram_addr];
            end
        end
    end
    assign ifc0.ram_dout = dout0;
    assign ifc1.ram_dout = dout1;

    // Reference model state
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fav = 0;
    int         sweep_idx = 0;
    logic [8:0] exp_mem [DEPTH];
    logic [8:0] last_d [2][2];
    rsp_t       q0 [$];
    rsp_t       q1 [$];
    logic       e_rdy0, e_rdy1, e_en, e_we, e_idone, e_full;
    logic [AW-1:0] e_addr;
    logic [8:0] e_din;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic rdy0, input logic rdy1, input logic en,
                             input logic we, input logic [AW-1:0] addr, input logic [8:0] din,
                             input logic ssr, input logic idone, input logic rv0, input logic rv1,
                             input logic [8:0] rd0, input logic [8:0] rd1);
        logic       ev0, ev1;
        logic [8:0] ed;
        rsp_t       r;
        ev0 = 1'b0; ev1 = 1'b0; ed = 9'h000;
        chk_val($sformatf("d%0d.r0_ready", k), rdy0, e_rdy0);
        chk_val($sformatf("d%0d.r1_ready", k), rdy1, e_rdy1);
        chk_val($sformatf("d%0d.ram_en", k), en, e_en);
        if (e_en || e_full) begin
            chk_val($sformatf("d%0d.ram_we", k), we, e_we);
            chk_val($sformatf("d%0d.ram_addr", k), addr, e_addr);
            chk_val($sformatf("d%0d.ram_din", k), din, e_din);
        end
        chk_val($sformatf("d%0d.ram_ssr", k), ssr, 1'b0);
        chk_val($sformatf("d%0d.init_done", k), idone, e_idone);
        if (k == 0) begin
            if (q0.size() > 0 && q0[0].cyc == cyc) begin
                r = q0.pop_front();
                ev0 = (r.id == 0); ev1 = (r.id == 1); ed = r.d;
            end
        end else begin
            if (q1.size() > 0 && q1[0].cyc == cyc) begin
                r = q1.pop_front();
                ev0 = (r.id == 0); ev1 = (r.id == 1); ed = r.d;
            end
        end
        chk_val($sformatf("d%0d.r0_rvalid", k), rv0, ev0);
        chk_val($sformatf("d%0d.r1_rvalid", k), rv1, ev1);
        chk_val($sformatf("d%0d.r0_rdata", k), rd0, ev0 ? ed : last_d[k][0]);
        chk_val($sformatf("d%0d.r1_rdata", k), rd1, ev1 ? ed : last_d[k][1]);
        if (ev0) last_d[k][0] = ed;
        if (ev1) last_d[k][1] = ed;
    endtask

    task automatic check_both();
        check_dut(0, ifc0.r0_ready, ifc0.r1_ready, ifc0.ram_en, ifc0.ram_we, ifc0.ram_addr,
                  ifc0.ram_din, ifc0.ram_ssr, ifc0.init_done, ifc0.r0_rvalid, ifc0.r1_rvalid,
                  ifc0.r0_rdata, ifc0.r1_rdata);
        check_dut(1, ifc1.r0_ready, ifc1.r1_ready, ifc1.ram_en, ifc1.ram_we, ifc1.ram_addr,
                  ifc1.ram_din, ifc1.ram_ssr, ifc1.init_done, ifc1.r0_rvalid, ifc1.r1_rvalid,
                  ifc1.r0_rdata, ifc1.r1_rdata);
    endtask

    // Called just after a rising edge; rst_n is released at the end.
    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            last_d[k][0] = 9'h000;
            last_d[k][1] = 9'h000;
        end
        fav = 0;
        sweep_idx = 0;
        @(negedge clk);
        e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_en = 1'b0; e_we = 1'b0;
        e_addr = '0; e_din = 9'h000; e_idone = 1'b0; e_full = 1'b1;
        check_both();
        cyc++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic iv0, input logic iwe0, input logic [AW-1:0] ia0, input logic [8:0] id0,
                         input logic iv1, input logic iwe1, input logic [AW-1:0] ia1, input logic [8:0] id1);
        int win;
        v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
        v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
        @(negedge clk);
        win = -1;
        e_full = 1'b0;
        e_idone = (sweep_idx >= DEPTH);
        if (sweep_idx < DEPTH) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = AW'(sweep_idx); e_din = 9'h000;
        end else begin
            if (iv0 && iv1) win = fav;
            else if (iv0) win = 0;
            else if (iv1) win = 1;
            e_en   = (win >= 0);
            e_we   = (win == 1) ? iwe1 : iwe0;
            e_addr = (win == 1) ? ia1 : ia0;
            e_din  = (win == 1) ? id1 : id0;
        end
        e_rdy0 = (win == 0);
        e_rdy1 = (win == 1);
        check_both();
        if (sweep_idx < DEPTH) begin
            exp_mem[sweep_idx] = 9'h000;
            sweep_idx++;
        end else if (win >= 0) begin
            fav = 1 - win;
            if (e_we) begin
                exp_mem[e_addr] = e_din;
            end else begin
                q0.push_back('{cyc: cyc + 1, id: win, d: exp_mem[e_addr]});
                q1.push_back('{cyc: cyc + 2, id: win, d: exp_mem[e_addr]});
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 9'h000, 1'b0, 1'b0, '0, 9'h000);
    endtask

    initial begin
        rst_n = 1'b0; scramble = 1'b1;
        v0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = 9'h000;
        v1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = 9'h000;
        @(posedge clk);
        @(posedge clk);
        #1;
        scramble = 1'b0;
        do_reset();

        // Sweep interrupted at address 7, then a complete sweep with valids held
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, AW'(i), 9'h000, 1'b1, 1'b0, AW'(i), 9'h000);
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, AW'(i), 9'h1FF, 1'b1, 1'b1, AW'(i), 9'h1FF);

        // Write then read back on requester 0
        cycle(1'b1, 1'b1, 4'd5, 9'h1A5, 1'b0, 1'b0, 4'd0, 9'h000);
        cycle(1'b1, 1'b0, 4'd5, 9'h000, 1'b0, 1'b0, 4'd0, 9'h000);
        idle(3);

        // Preload; r1 moves last so contention starts with r0
        cycle(1'b1, 1'b1, 4'd1, 9'h011, 1'b0, 1'b0, 4'd0, 9'h000);
        cycle(1'b0, 1'b0, 4'd0, 9'h000, 1'b1, 1'b1, 4'd2, 9'h022);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 4'd1, 9'h000, 1'b1, 1'b0, 4'd2, 9'h000);
        idle(3);

        // Requester 1 read of addr 3 (two-cycle path on dut1)
        cycle(1'b0, 1'b0, 4'd0, 9'h000, 1'b1, 1'b1, 4'd3, 9'h133);
        cycle(1'b0, 1'b0, 4'd0, 9'h000, 1'b1, 1'b0, 4'd3, 9'h000);
        idle(3);

        // Random traffic including boundary addresses
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 6), 1'($urandom), AW'($urandom), 9'($urandom),
                  ($urandom_range(0, 9) < 6), 1'($urandom), AW'($urandom), 9'($urandom));
        end
        idle(3);

        // Reset one cycle after a read accept: the response must vanish
        cycle(1'b1, 1'b0, 4'd5, 9'h000, 1'b0, 1'b0, 4'd0, 9'h000);
        do_reset();
        idle(DEPTH + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
